// File: rtl/fc_mac_sequencer.sv
// Sequences weight/activation fetches into a two-stage MAC for one FC layer,
// flushes and captures each neuron sum, and hands results out over valid/ready.
module fc_mac_sequencer #(
  parameter int unsigned N_MAX    = 1024,
  parameter int unsigned M_MAX    = 256,
  parameter int unsigned W_ADDR_W = 18,
  parameter int unsigned D_ADDR_W = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(N_MAX):0]        n_in,
  input  logic [$clog2(M_MAX):0]        n_out,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [W_ADDR_W-1:0]           w_addr,
  output logic [D_ADDR_W-1:0]           d_addr,
  input  logic signed [7:0]             w_rdata,
  input  logic signed [31:0]            d_rdata,
  output logic                          mac_valid,
  output logic signed [7:0]             mac_weight,
  output logic signed [31:0]            mac_data,
  input  logic signed [31:0]            mac_dout,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic signed [31:0]            res_data,
  output logic [$clog2(M_MAX)-1:0]      res_idx
);

  localparam int unsigned N_W   = $clog2(N_MAX) + 1;
  localparam int unsigned M_W   = $clog2(M_MAX) + 1;
  localparam int unsigned IDX_W = $clog2(M_MAX);

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, FLUSH, CAPTURE, RESULT
  } state_e;

  state_e               state, state_d;
  logic [N_W-1:0]       n_in_q;
  logic [M_W-1:0]       n_out_q;
  logic [IDX_W-1:0]     neuron_q, neuron_d;
  logic                 pass_q;
  logic                 fetch_last, neuron_last;

  logic                 busy_d, done_d, rd_en_d, mac_valid_d, pass_d, res_valid_d;
  logic [W_ADDR_W-1:0]  w_addr_d;
  logic [D_ADDR_W-1:0]  d_addr_d;

  // d_addr doubles as the per-neuron input index i
  assign fetch_last  = (N_W'(d_addr) == n_in_q - N_W'(1));
  assign neuron_last = (M_W'(neuron_q) == n_out_q - M_W'(1));

  // RAM data arrives combinationally one cycle after rd_en; gate it onto the MAC
  assign mac_weight = pass_q ? w_rdata : 8'sd0;
  assign mac_data   = pass_q ? d_rdata : 32'sd0;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_in_q    <= '0;
      n_out_q   <= '0;
      neuron_q  <= '0;
      pass_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      mac_valid <= 1'b0;
      res_valid <= 1'b0;
      w_addr    <= '0;
      d_addr    <= '0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      state     <= state_d;
      neuron_q  <= neuron_d;
      pass_q    <= pass_d;
      busy      <= busy_d;
      done      <= done_d;
      rd_en     <= rd_en_d;
      mac_valid <= mac_valid_d;
      res_valid <= res_valid_d;
      w_addr    <= w_addr_d;
      d_addr    <= d_addr_d;
      if (state == IDLE && start) begin
        n_in_q  <= n_in;
        n_out_q <= n_out;
      end
      if (state == CAPTURE) begin
        res_data <= mac_dout;
        res_idx  <= neuron_q;
      end
    end
  end

  // Next-state and neuron counter
  always_comb begin
    state_d  = state;
    neuron_d = neuron_q;
    case (state)
      IDLE: begin
        if (start) begin
          neuron_d = '0;
          if (n_out == '0)     state_d = IDLE;
          else if (n_in == '0) state_d = FLUSH;
          else                 state_d = FETCH;
        end
      end
      FETCH:   if (fetch_last) state_d = DRAIN;
      DRAIN:   state_d = FLUSH;
      FLUSH:   state_d = CAPTURE;
      CAPTURE: state_d = RESULT;
      RESULT: begin
        if (res_ready) begin
          if (neuron_last) begin
            state_d = IDLE;
          end else begin
            neuron_d = neuron_q + IDX_W'(1);
            state_d  = (n_in_q == '0) ? FLUSH : FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of registered outputs, decoded from the upcoming state
  always_comb begin
    busy_d      = (state_d != IDLE);
    rd_en_d     = (state_d == FETCH);
    mac_valid_d = (state_d == FETCH && state == FETCH) ||
                  (state_d == DRAIN) || (state_d == FLUSH);
    pass_d      = (state_d == FETCH) || (state_d == DRAIN);
    res_valid_d = (state_d == RESULT);
    done_d      = (state == IDLE && start && n_out == '0) ||
                  (state == RESULT && res_ready && neuron_last);
    w_addr_d    = w_addr;
    d_addr_d    = d_addr;
    if (state_d == FETCH) begin
      // weight rows are contiguous, so w_addr simply keeps counting across neurons
      w_addr_d = (state == IDLE)  ? '0 : w_addr + W_ADDR_W'(1);
      d_addr_d = (state == FETCH) ? d_addr + D_ADDR_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Directed bench: sync-read RAM models plus a two-stage MAC model around the sequencer.
module tb_fc_mac_sequencer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [10:0]        n_in;
  logic [8:0]         n_out;
  logic               busy, done, rd_en;
  logic [17:0]        w_addr;
  logic [9:0]         d_addr;
  logic signed [7:0]  w_rdata;
  logic signed [31:0] d_rdata;
  logic               mac_valid;
  logic signed [7:0]  mac_weight;
  logic signed [31:0] mac_data;
  logic signed [31:0] mac_dout;
  logic               res_valid, res_ready;
  logic signed [31:0] res_data;
  logic [7:0]         res_idx;

  fc_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .n_out(n_out),
    .busy(busy), .done(done), .rd_en(rd_en), .w_addr(w_addr), .d_addr(d_addr),
    .w_rdata(w_rdata), .d_rdata(d_rdata), .mac_valid(mac_valid),
    .mac_weight(mac_weight), .mac_data(mac_data), .mac_dout(mac_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  logic signed [7:0]  wmem [0:15];
  logic signed [31:0] dmem [0:15];

  always @(posedge clk) begin
    if (rd_en) begin
      w_rdata <= wmem[w_addr[3:0]];
      d_rdata <= dmem[d_addr[3:0]];
    end
  end

  // MAC: product stage then accumulate stage; Cal_Valid low clears both
  logic signed [31:0] prod, acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      acc  <= '0;
    end else if (mac_valid) begin
      prod <= $signed({{24{mac_weight[7]}}, mac_weight}) * mac_data;
      acc  <= acc + prod;
    end else begin
      prod <= '0;
      acc  <= '0;
    end
  end
  assign mac_dout = acc;

  int total = 0;
  int bad   = 0;

  logic [63:0] mv, rv, dn, re, bz;
  int          first_cyc;
  logic [31:0] first_data;
  logic [7:0]  first_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps ncyc cycles after a start in cycle 0, logging outputs per cycle
  task automatic run(input int ncyc);
    mv = '0; rv = '0; dn = '0; re = '0; bz = '0;
    first_cyc = -1; first_data = '0; first_idx = '0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start = 1'b0;
      mv[c] = mac_valid; rv[c] = res_valid; dn[c] = done;
      re[c] = rd_en;     bz[c] = busy;
      if (res_valid && first_cyc < 0) begin
        first_cyc  = c;
        first_data = res_data;
        first_idx  = res_idx;
      end
    end
  endtask

  task automatic load_t1();
    wmem[0] = 8'sd1;   wmem[1] = 8'sd2;   wmem[2] = 8'sd3;
    dmem[0] = 32'sd10; dmem[1] = 32'sd20; dmem[2] = 32'sd30;
  endtask

  logic [17:0] wlog [0:7];
  logic [9:0]  dlog [0:7];
  int          nlog, hold_bad, dcount;
  logic [31:0] r2d;
  logic [7:0]  r2i;
  logic        r2v;

  initial begin
    for (int k = 0; k < 16; k++) begin
      wmem[k] = '0;
      dmem[k] = '0;
    end
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b1; n_in = '0; n_out = '0;
    step(); step();
    chk("rst_busy",  64'(busy), 0);
    chk("rst_done",  64'(done), 0);
    chk("rst_rd_en", 64'(rd_en), 0);
    chk("rst_mac_valid", 64'(mac_valid), 0);
    chk("rst_res_valid", 64'(res_valid), 0);
    chk("rst_addr", {w_addr, d_addr}, 0);
    chk("rst_res", {res_data, res_idx}, 0);
    rst_n = 1'b1;
    step();

    // basic dot product: 1*10+2*20+3*30
    load_t1();
    n_in = 11'd3; n_out = 9'd1; start = 1'b1;
    run(10);
    chk("t1_first_cyc", 64'(first_cyc), 7);
    chk("t1_data", 64'(first_data), 140);
    chk("t1_idx", 64'(first_idx), 0);
    chk("t1_mac_valid", mv, 64'h3C);
    chk("t1_res_valid", rv, 64'h80);
    chk("t1_done", dn, 64'h100);
    chk("t1_busy", bz, 64'hFE);
    chk("t1_rd_en", re, 64'h0E);

    // signed extremes: -128*2 + 127*-1 = -383
    wmem[0] = -8'sd128; wmem[1] = 8'sd127;
    dmem[0] = 32'sd2;   dmem[1] = -32'sd1;
    n_in = 11'd2; n_out = 9'd1; start = 1'b1;
    run(8);
    chk("t2_first_cyc", 64'(first_cyc), 6);
    chk("t2_data", 64'(first_data), 64'hFFFFFE81);
    chk("t2_done", dn, 64'h80);

    // two neurons with back-pressure on the first result
    for (int k = 0; k < 8; k++) wmem[k] = 8'(k + 1);
    for (int k = 0; k < 4; k++) dmem[k] = 32'(k + 1);
    n_in = 11'd4; n_out = 9'd2; res_ready = 1'b0; start = 1'b1;
    re = '0; dn = '0; nlog = 0; hold_bad = 0; r2d = '0; r2i = '0; r2v = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      step();
      start = 1'b0;
      if (c == 13) res_ready = 1'b1;
      re[c] = rd_en; dn[c] = done;
      if (rd_en && nlog < 8) begin
        wlog[nlog] = w_addr;
        dlog[nlog] = d_addr;
        nlog++;
      end
      if (c >= 8 && c <= 13)
        if (!(res_valid === 1'b1 && res_data === 32'sd30 && res_idx === 8'd0)) hold_bad++;
      if (c == 21) begin
        r2d = res_data; r2i = res_idx; r2v = res_valid;
      end
    end
    chk("t3_hold_stable", 64'(hold_bad), 0);
    chk("t3_rd_en", re, 64'h3C01E);
    chk("t3_nfetch", 64'(nlog), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t3_addr%0d", k), {wlog[k], dlog[k]}, {18'(k), 10'(k % 4)});
    chk("t3_r2", {r2v, r2i, r2d}, {1'b1, 8'd1, 32'd70});
    chk("t3_done", dn, 64'h400000);

    // empty neuron: flush straight away, sum is 0
    n_in = 11'd0; n_out = 9'd1; start = 1'b1;
    run(6);
    chk("t4a_first_cyc", 64'(first_cyc), 3);
    chk("t4a_data", 64'(first_data), 0);
    chk("t4a_rd_en", re, 0);
    chk("t4a_mac_valid", mv, 64'h2);
    chk("t4a_done", dn, 64'h10);

    // no neurons: immediate done
    n_in = 11'd3; n_out = 9'd0; start = 1'b1;
    run(4);
    chk("t4b_done", dn, 64'h2);
    chk("t4b_res_valid", rv, 0);
    chk("t4b_rd_en", re, 0);
    chk("t4b_busy", bz, 0);

    // 32-bit wraparound of the sum
    wmem[0] = 8'sd127; wmem[1] = 8'sd127;
    dmem[0] = 32'sh7FFFFFFF; dmem[1] = 32'sh7FFFFFFF;
    n_in = 11'd2; n_out = 9'd1; start = 1'b1;
    run(8);
    chk("t5_data", 64'(first_data), 64'hFFFFFF02);

    // reset in the middle of FETCH, then a clean rerun
    load_t1();
    n_in = 11'd3; n_out = 9'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 0);
    chk("t6_rd_en", 64'(rd_en), 0);
    chk("t6_mac", {mac_valid, mac_weight, mac_data}, 0);
    chk("t6_addr", {w_addr, d_addr}, 0);
    step();
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done || busy || res_valid) dcount++;
    end
    chk("t6_quiet", 64'(dcount), 0);
    n_in = 11'd3; n_out = 9'd1; start = 1'b1;
    run(10);
    chk("t6_first_cyc", 64'(first_cyc), 7);
    chk("t6_data", 64'(first_data), 140);
    chk("t6_done", dn, 64'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_mac_sequencer.md
# fc_mac_sequencer

Drives one fully-connected MAC lane for a layer: fetches weight and input-activation pairs from synchronous-read memories and presents them to the MAC with its `Cal_Valid` strobe. It then injects the flush cycle the MAC's two-stage multiply/accumulate needs, captures the MAC's `Dout` at the exact cycle the sum is complete, and returns one result per output neuron over a valid/ready handshake. It sits between the layer controller (`start`/`done`), the weight and activation RAMs, and a single MAC instance sharing `clk`/`rst_n`.

## Interface
- N_MAX, 1024, maximum inputs per neuron (n_in)
- M_MAX, 256, maximum output neurons (n_out)
- W_ADDR_W, 18, weight RAM address width (≥ log2(N_MAX*M_MAX))
- D_ADDR_W, 10, activation RAM address width (≥ log2(N_MAX))

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin layer; sampled only in IDLE
- n_in  in  log2(N_MAX)+1  inputs per neuron, latched at start
- n_out  in  log2(M_MAX)+1  neurons, latched at start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse, layer complete
- rd_en  out  1  read strobe to both RAMs
- w_addr  out  W_ADDR_W  weight address = neuron*n_in + i
- d_addr  out  D_ADDR_W  activation address = i
- w_rdata  in  8 signed  weight, valid cycle after rd_en
- d_rdata  in  32 signed  activation, valid cycle after rd_en
- mac_valid  out  1  to MAC Cal_Valid
- mac_weight  out  8 signed  to MAC weight
- mac_data  out  32 signed  to MAC data
- mac_dout  in  32 signed  MAC Dout
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  32 signed  neuron sum
- res_idx  out  log2(M_MAX)  neuron index of res_data

## Operation
- States: IDLE, FETCH, DRAIN, FLUSH, CAPTURE, RESULT.
- IDLE: start=1 latches n_in/n_out, neuron=0. If n_out=0, go to IDLE and pulse done next cycle. Else go to FETCH, or to FLUSH if n_in=0.
- FETCH: rd_en=1, i counts 0..n_in-1, one address per cycle. After i=n_in-1, go to DRAIN.
- DRAIN: rd_en=0; the last fetched pair is presented. Go to FLUSH.
- FLUSH: mac_valid=1, mac_weight=0, mac_data=0. Pushes the MAC's last buffered product into Dout. Go to CAPTURE.
- CAPTURE: mac_valid=0, which clears the MAC at this edge. Registers res_data←mac_dout and res_idx←neuron. Go to RESULT.
- RESULT: res_valid=1, with res_data/res_idx held stable until res_valid&res_ready.
  - On handshake with neuron<n_out-1: neuron+1, i=0, go to FETCH (or FLUSH if n_in=0).
  - On handshake with the last neuron: go to IDLE and pulse done.
- mac_valid=1 exactly in FETCH with i≥1, DRAIN, and FLUSH. mac_weight/mac_data pass w_rdata/d_rdata in FETCH/DRAIN, and are 0 otherwise.
- mac_valid is guaranteed low for ≥1 cycle between neurons (CAPTURE), so the MAC starts every neuron from 0.
- Arithmetic belongs to the MAC. The per-product and running sum are 32-bit, wrapping mod 2^32. The sequencer never modifies the sum.
- start while busy is ignored. n_in>N_MAX or n_out>M_MAX is undefined.

## Timing
- Reset (async, rst_n=0): state IDLE. busy, done, rd_en, mac_valid, res_valid = 0. All addresses, mac_weight, mac_data, res_data, res_idx = 0. Counters = 0. Reset mid-operation abandons the layer; no done is produced.
- Start accepted in cycle 0:
  - FETCH occupies cycles 1..n_in.
  - DRAIN n_in+1, FLUSH n_in+2, CAPTURE n_in+3.
  - res_valid is first high at cycle n_in+4.
- Per-neuron minimum with res_ready held high: n_in+4 cycles. The next FETCH begins the cycle after the handshake.
- done is high the cycle after the final handshake; busy falls in that same cycle.
- n_in=0: FLUSH at cycle 1, res_valid at cycle 3, res_data=0.
- res_ready is ignored unless res_valid=1.

## Test plan
- n_in=3, n_out=1, w={1,2,3}, d={10,20,30}, res_ready=1, start at cycle 0 → res_valid at cycle 7 with res_data=140, res_idx=0; done at cycle 8; mac_valid high cycles 2..5.
- n_in=2, w={-128,127}, d={2,-1} → res_data=-383 (0xFFFFFE81).
- n_in=4, n_out=2, res_ready low for 5 cycles on the first result → res_valid/res_data/res_idx stable throughout; no rd_en until the handshake; w_addr 0..3 then 4..7, d_addr 0..3 twice; second res_idx=1.
- n_in=0, n_out=1 → res_data=0 at cycle 3. Separately, n_out=0 → done at cycle 1, no res_valid, no rd_en.
- n_in=2, w={127,127}, d={0x7FFFFFFF,0x7FFFFFFF} → res_data=0xFFFFFF02 (mod-2^32 wrap).
- rst_n pulsed low in cycle 2 of FETCH → all outputs 0 immediately, IDLE, no done. A fresh start with test-1 data → 140 at cycle 7.
